// File: rtl/wiegand_rx.sv
// wiegand_rx: 26-bit Wiegand receiver with pulse filtering, length check and ack/int host handshake.
// Define WIEGAND_RX_PARITY_EN to add the leading-even / trailing-odd parity check.
module wiegand_rx #(
  parameter int PULSE_MIN    = 10,
  parameter int PULSE_MAX    = 60,
  parameter int IDLE_TIMEOUT = 200,
  parameter int FRAME_BITS   = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  i_wigend_in,
  input  logic        i_ack,
  output logic [25:0] o_data,
  output logic        o_int,
  output logic        o_err,
  output logic        o_overrun
);
  typedef enum logic [2:0] {S_IDLE, S_LOW0, S_LOW1, S_GAP, S_EVAL, S_FAULT} state_t;
  localparam logic [12:0] L_MIN  = 13'(PULSE_MIN);
  localparam logic [12:0] L_MAX  = 13'(PULSE_MAX);
  localparam logic [12:0] L_TO   = 13'(IDLE_TIMEOUT);
  // The two synchronizer cycles already belong to the idle window, so the
  // gap count ends early enough that int falls IDLE_TIMEOUT+3 after the raw rise.
  localparam logic [12:0] L_GAP_END = 13'(IDLE_TIMEOUT - 2);
  localparam logic [4:0]  L_BITS = 5'(FRAME_BITS);
  localparam logic [4:0]  L_SR   = 5'd26;
  state_t      r_state;
  logic [1:0]  r_sync1, r_sync2;
  logic [12:0] r_timer;
  logic [4:0]  r_cnt;
  logic [25:0] r_sr;
  logic        w_s0, w_s1, w_mine, w_other, w_width_ok, w_parity_ok;
  logic [12:0] w_timer_inc;
  logic [4:0]  w_cnt_inc;
  assign w_s0        = r_sync2[0];
  assign w_s1        = r_sync2[1];
  assign w_mine      = (r_state == S_LOW1) ? w_s1 : w_s0;
  assign w_other     = (r_state == S_LOW1) ? w_s0 : w_s1;
  assign w_width_ok  = (r_timer >= L_MIN) && (r_timer <= L_MAX);
  assign w_timer_inc = (&r_timer) ? r_timer : r_timer + 13'd1;
  assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + 5'd1;
`ifdef WIEGAND_RX_PARITY_EN
  assign w_parity_ok = ~(^r_sr[12:0]) & (^r_sr[25:13]);
`else
  assign w_parity_ok = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_sync1   <= 2'b11;
      r_sync2   <= 2'b11;
      r_timer   <= '0;
      r_cnt     <= '0;
      r_sr      <= '0;
      o_data    <= '0;
      o_int     <= 1'b1;
      o_err     <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      r_sync1 <= i_wigend_in;
      r_sync2 <= r_sync1;
      o_err   <= 1'b0;
      if (i_ack) begin
        o_int     <= 1'b1;
        o_overrun <= 1'b0;
      end
      case (r_state)
        S_IDLE, S_GAP: begin
          if (!w_s0 && !w_s1) begin
            r_state <= S_FAULT;
            r_timer <= '0;
            o_err   <= 1'b1;
          end else if (!w_s0) begin
            r_state <= S_LOW0;
            r_timer <= 13'd1;
          end else if (!w_s1) begin
            r_state <= S_LOW1;
            r_timer <= 13'd1;
          end else if (r_state == S_GAP) begin
            if (r_timer >= L_GAP_END) r_state <= S_EVAL;
            else r_timer <= w_timer_inc;
          end
        end
        S_LOW0, S_LOW1: begin
          if (!w_other || (w_mine && !w_width_ok)) begin
            r_state <= S_FAULT;
            r_timer <= '0;
            o_err   <= 1'b1;
          end else if (w_mine) begin
            if (r_cnt < L_SR) r_sr[r_cnt] <= (r_state == S_LOW1);
            r_cnt   <= w_cnt_inc;
            r_timer <= '0;
            r_state <= S_GAP;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        S_EVAL: begin
          if (r_cnt != L_BITS || !w_parity_ok) begin
            o_err <= 1'b1;
          end else if (o_int || i_ack) begin
            o_data <= r_sr;
            o_int  <= 1'b0;
          end else begin
            o_overrun <= 1'b1;
          end
          r_cnt   <= '0;
          r_sr    <= '0;
          r_timer <= '0;
          r_state <= S_IDLE;
        end
        S_FAULT: begin
          if (!w_s0 || !w_s1) begin
            r_timer <= '0;
          end else if (w_timer_inc >= L_TO) begin
            r_cnt   <= '0;
            r_sr    <= '0;
            r_timer <= '0;
            r_state <= S_IDLE;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wiegand_rx.sv
// tb_wiegand_rx: directed frames; a monitor checks each int fall / err pulse against a queue of expected events.
module tb_wiegand_rx;
  typedef struct {
    bit          is_err;
    logic [25:0] d;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  wl = 2'b11;
  logic        ack = 1'b0;
  logic [25:0] data;
  logic        int_n, err, overrun;
  int          total = 0;
  int          bad = 0;
  exp_t        q[$];
  logic        prev_int = 1'b1;

  wiegand_rx dut (
    .clk(clk), .rst(rst), .i_wigend_in(wl), .i_ack(ack),
    .o_data(data), .o_int(int_n), .o_err(err), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, a, e);
    end
  endtask

  task automatic push(input bit is_err, input logic [25:0] d);
    exp_t e;
    e.is_err = is_err;
    e.d = d;
    q.push_back(e);
  endtask

  task automatic mon_event(input bit is_err);
    exp_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL monitor unexpected %s data=%h", is_err ? "err" : "frame", data);
    end else begin
      e = q.pop_front();
      if (e.is_err != is_err || (!is_err && e.d !== data)) begin
        bad++;
        $display("FAIL monitor got %s data=%h exp %s data=%h",
                 is_err ? "err" : "frame", data, e.is_err ? "err" : "frame", e.d);
      end
    end
  endtask

  always @(negedge clk) begin
    if (err) mon_event(1'b1);
    if (prev_int && !int_n) mon_event(1'b0);
    prev_int = int_n;
  end

  task automatic send_frame(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 wl[v[i]] = 1'b0;
      repeat (28) @(posedge clk);
      #1 wl = 2'b11;
      if (i < n - 1) repeat (56) @(posedge clk);
    end
  endtask

  task automatic do_ack();
    @(posedge clk);
    #1 ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", {6'b0, data}, 32'h0);
    chk("rst_int", {31'b0, int_n}, 32'h1);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_ovr", {31'b0, overrun}, 32'h0);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    // 1: valid frame, latency to int
    push(1'b0, 26'h2000003);
    send_frame(32'h2000003, 26);
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (!int_n) begin
        n = i;
        break;
      end
    end
    chk("t1_latency", n, 203);
    chk("t1_data", {6'b0, data}, 32'h2000003);
    ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
    chk("t1_ack_int", {31'b0, int_n}, 32'h1);
    // 2: all-zero frame
`ifdef WIEGAND_RX_PARITY_EN
    push(1'b1, 26'h0);
    send_frame(32'h0, 26);
    repeat (250) @(posedge clk);
    #1;
    chk("t2_int", {31'b0, int_n}, 32'h1);
    chk("t2_data", {6'b0, data}, 32'h2000003);
`else
    push(1'b0, 26'h0);
    send_frame(32'h0, 26);
    repeat (250) @(posedge clk);
    #1;
    chk("t2_int", {31'b0, int_n}, 32'h0);
    chk("t2_data", {6'b0, data}, 32'h0);
    do_ack();
`endif
    // 3: wrong lengths
    push(1'b1, 26'h0);
    send_frame(32'h2000003, 25);
    repeat (250) @(posedge clk);
    push(1'b1, 26'h0);
    send_frame(32'h2000003, 27);
    repeat (250) @(posedge clk);
    #1;
    chk("t3_int", {31'b0, int_n}, 32'h1);
    // 4: glitch on D1 mid-frame, then recovery
    send_frame(32'h2000003, 10);
    repeat (56) @(posedge clk);
    push(1'b1, 26'h0);
    @(posedge clk);
    #1 wl[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1 wl = 2'b11;
    repeat (300) @(posedge clk);
    push(1'b0, 26'h2000003);
    send_frame(32'h2000003, 26);
    repeat (250) @(posedge clk);
    #1;
    chk("t4_data", {6'b0, data}, 32'h2000003);
    do_ack();
    // 5: overrun
    push(1'b0, 26'h2000003);
    send_frame(32'h2000003, 26);
    repeat (250) @(posedge clk);
    send_frame(32'h2000000, 26);
    repeat (250) @(posedge clk);
    #1;
    chk("t5_data", {6'b0, data}, 32'h2000003);
    chk("t5_ovr", {31'b0, overrun}, 32'h1);
    chk("t5_int", {31'b0, int_n}, 32'h0);
    do_ack();
    chk("t5_ack_ovr", {31'b0, overrun}, 32'h0);
    chk("t5_ack_int", {31'b0, int_n}, 32'h1);
    // 6: reset during bit 13
    send_frame(32'h2000003, 12);
    repeat (56) @(posedge clk);
    @(posedge clk);
    #1 wl[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("t6_data", {6'b0, data}, 32'h0);
    chk("t6_int", {31'b0, int_n}, 32'h1);
    chk("t6_err", {31'b0, err}, 32'h0);
    chk("t6_ovr", {31'b0, overrun}, 32'h0);
    wl = 2'b11;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    push(1'b0, 26'h2000000);
    send_frame(32'h2000000, 26);
    repeat (250) @(posedge clk);
    #1;
    chk("t6_frame", {6'b0, data}, 32'h2000000);
    // 7: ack in the same cycle as EVAL loads the new frame
    send_frame(32'h2000003, 26);
    repeat (202) @(posedge clk);
    #1 ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
    chk("t7_int", {31'b0, int_n}, 32'h0);
    chk("t7_data", {6'b0, data}, 32'h2000003);
    chk("t7_ovr", {31'b0, overrun}, 32'h0);
    do_ack();
    repeat (5) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wiegand_rx.md
Name: wiegand_rx

Overview:
Wiegand 26-bit receiver. It is the consuming stage for the CPLD Wiegand transmitter's two-line output (or an external reader on the same connector). It samples the D0/D1 line pair, filters and decodes the bit pulses, and assembles a 26-bit frame with first-received bit in data[0]. It checks frame length and parity, then presents the frame to the host bus with an active-low interrupt and ack handshake.

Parameters:
PULSE_MIN, 10, minimum accepted low-pulse width in clk cycles (glitch reject)
PULSE_MAX, 60, maximum accepted low-pulse width in clk cycles
IDLE_TIMEOUT, 200, clk cycles of both lines high that terminate a frame
FRAME_BITS, 26, required bit count per frame

Ports:
clk  input  1  system clock, 1 MHz nominal (1 cycle = 1 us)
rst  input  1  asynchronous, active-low reset
wigend_in  input  2  raw Wiegand lines; [0]=D0 (low = bit 0), [1]=D1 (low = bit 1); idle high
ack  input  1  host acknowledge; high for >=1 clk releases int and clears overrun
data  output  26  last accepted frame; data[0] = first bit received
int  output  1  active-low frame-ready interrupt; level, held until ack
err  output  1  one-clk high pulse per discarded frame or line fault
overrun  output  1  sticky; a valid frame arrived while int was low

Behaviour:
- Reset (rst=0, async): data=0, int=1, err=0, overrun=0, state IDLE, counters 0, synchronizer flops = 1. Reset mid-frame discards the partial frame; no err.
- Input sync: 2-flop synchronizer per line; all decoding uses synchronized values s0/s1.
- Width timer: 13-bit, saturating at 8191. Bit counter: 5-bit, saturating at 31. Shift register: 26-bit, bit n written at index n (bit counter value) while count < 26.
- FSM:
  - IDLE: both high. s0 low only -> LOW0, timer=1. s1 low only -> LOW1, timer=1. Both low -> FAULT.
  - LOW0/LOW1: timer counts each clk while the line stays low. On the line rising:
    - PULSE_MIN <= width <= PULSE_MAX: store bit (0 for LOW0, 1 for LOW1), count+1, go GAP, timer=0.
    - Width outside that range: FAULT.
  - Either state, other line going low: FAULT.
  - GAP: both high, timer counts. s0/s1 low -> LOW0/LOW1 as from IDLE. Timer reaching IDLE_TIMEOUT -> EVAL.
  - EVAL (1 clk):
    - count != FRAME_BITS: err pulse, no data update.
    - Parity failure (see Optional Feature): err pulse, no data update.
    - Otherwise, if int=1: data <= shift register, int <= 0.
    - Otherwise (int=0): data unchanged, overrun <= 1, no err.
    - Clear count and shift register, go IDLE.
  - FAULT: err pulse on entry. Wait until both lines are high for IDLE_TIMEOUT clks, then clear and go IDLE.
- Latency: int falls exactly IDLE_TIMEOUT+3 clk after the raw rising edge of the last bit (2 sync + timeout + EVAL).
- Handshake: ack=1 sampled at a clk edge sets int=1 and overrun=0 on that edge. If ack and EVAL are in the same cycle, EVAL loads the new frame and int stays 0; overrun stays clear.
- A frame arriving from IDLE while int=0 is still decoded; only the load is blocked.

Optional Feature:
WIEGAND_RX_PARITY_EN
- Defined: EVAL checks both parity bits.
  - Even parity: data[0] XOR data[12:1] reduction = 0.
  - Odd parity: data[25] XOR data[24:13] reduction = 1.
  - Either failure -> err pulse, frame discarded.
- Undefined: no parity logic; any FRAME_BITS-long frame is accepted.

Test Plan:
1. Transmitter-timed frame (28 us pulses, 85 us period) carrying 26'h2000003 -> int=0 at last raw rise + 203 clk, data=26'h2000003, err=0; ack pulse -> int=1 next edge.
2. Same timing, frame 26'h0000000, macro defined -> err one-clk pulse, int stays 1, data unchanged. Same frame with macro undefined -> data=26'h0000000, int=0.
3. 25-bit frame, then 27-bit frame -> err pulse each, int stays 1, no data change.
4. 5-clk low glitch on D1 mid-frame -> FAULT, err pulse. After 200 idle clk, valid frame 26'h2000003 decodes normally.
5. Two valid frames (26'h2000003 then 26'h2000000), no ack between -> data=26'h2000003, overrun=1, int=0. ack -> overrun=0, int=1.
6. rst asserted during bit 13 of a frame -> outputs at reset values immediately. Next full valid frame decodes correctly with count starting at 0.
